// File: rtl/const_rom_arbiter_if.sv
// ============================================================================
// Module   : const_rom_arbiter_if
// Brief    : Requester / response bundle for the two-port constant ROM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface const_rom_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [2:0]       req0_idx;
  logic             req0_ready;
  logic             req1_valid;
  logic [2:0]       req1_idx;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic             rsp_id;
  logic             rsp_err;
  logic [CNT_W-1:0] served0;
  logic [CNT_W-1:0] served1;

  modport slave (
    input  req0_valid, req0_idx, req1_valid, req1_idx, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
           served0, served1
  );

  modport master (
    output req0_valid, req0_idx, req1_valid, req1_idx, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
           served0, served1
  );
endinterface

`default_nettype wire

// File: rtl/const_rom_arbiter.sv
// ============================================================================
// Module   : const_rom_arbiter
// Brief    : Round-robin arbiter between two requesters for a 6-entry ROM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module const_rom_arbiter #(
  parameter int RR_INIT = 0,
  parameter int CNT_W   = 8
) (
  input  wire logic           sysclk,
  input  wire logic           rst_n,
  const_rom_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state;
  logic             r_prio;
  logic             r_id;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_served0;
  logic [CNT_W-1:0] r_served1;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_data;
  logic             r_rsp_id;
  logic             r_rsp_err;

  logic w_idle;
  logic w_pick1;
  logic w_gnt0;
  logic w_gnt1;

  function automatic logic [15:0] rom_word(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_word = 16'h007B;
      3'd1:    rom_word = 16'h0B77;
      3'd2:    rom_word = 16'hFEF2;
      3'd3:    rom_word = 16'h04D2;
      3'd4:    rom_word = 16'h064A;
      3'd5:    rom_word = 16'h12AF;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  // rst_n is folded in so the readies are forced low for the whole reset.
  assign w_idle  = rst_n && (r_state == ST_IDLE);
  assign w_pick1 = bus.req1_valid && (!bus.req0_valid || r_prio);
  assign w_gnt0  = w_idle && bus.req0_valid && !w_pick1;
  assign w_gnt1  = w_idle && w_pick1;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prio      <= (RR_INIT != 0);
      r_id        <= 1'b0;
      r_idx       <= 3'd0;
      r_served0   <= '0;
      r_served1   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_idx   <= w_gnt1 ? bus.req1_idx : bus.req0_idx;
            r_id    <= w_gnt1;
            r_prio  <= ~r_prio;
            r_state <= ST_READ;
            if (w_gnt0 && (r_served0 != c_cnt_max)) r_served0 <= r_served0 + 1'b1;
            if (w_gnt1 && (r_served1 != c_cnt_max)) r_served1 <= r_served1 + 1'b1;
          end
        end
        ST_READ: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= rom_word(r_idx);
          r_rsp_id    <= r_id;
          r_rsp_err   <= r_idx[2] & r_idx[1];
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          // Response fields return to zero together with rsp_valid.
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.served0    = r_served0;
  assign bus.served1    = r_served1;

endmodule

`default_nettype wire

// File: tb/tb_const_rom_arbiter.sv
// ============================================================================
// Module   : tb_const_rom_arbiter
// Brief    : Directed plus randomized bench against a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_const_rom_arbiter;

  logic sysclk = 1'b0;
  logic rst_n;
  always #5 sysclk = ~sysclk;

  const_rom_arbiter_if #(.CNT_W(8)) bus ();
  const_rom_arbiter_if #(.CNT_W(2)) bus_s ();

  assign bus_s.req0_valid = bus.req0_valid;
  assign bus_s.req0_idx   = bus.req0_idx;
  assign bus_s.req1_valid = bus.req1_valid;
  assign bus_s.req1_idx   = bus.req1_idx;
  assign bus_s.rsp_ready  = bus.rsp_ready;

  const_rom_arbiter #(.RR_INIT(0), .CNT_W(8)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  const_rom_arbiter #(.RR_INIT(0), .CNT_W(2)) dut_s (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus_s.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] tbl(input int idx);
    logic [15:0] t [0:5];
    t = '{16'h007B, 16'h0B77, 16'hFEF2, 16'h04D2, 16'h064A, 16'h12AF};
    return (idx < 6) ? t[idx] : 16'h0000;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Transaction model: a lookup is outstanding for a number of cycles after
  // acceptance, and its response is visible from the second cycle onward.
  bit          m_busy;
  int          m_age;
  logic [15:0] m_data;
  bit          m_id;
  bit          m_err;
  bit          m_prio;
  int          m_cnt0, m_cnt1;
  bit          acc0, acc1;

  always @(negedge sysclk) begin
    bit e_r0, e_r1, e_rv;
    int idx;
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    end
    e_rv = m_busy && (m_age >= 2);
    e_r0 = 0;
    e_r1 = 0;
    if (rst_n && !m_busy) begin
      if (bus.req0_valid && bus.req1_valid) begin
        e_r0 = !m_prio; e_r1 = m_prio;
      end else begin
        e_r0 = bus.req0_valid; e_r1 = bus.req1_valid;
      end
    end
    check("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
    check("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
    check("rsp_valid",  32'(bus.rsp_valid),  32'(e_rv));
    check("rsp_data",   32'(bus.rsp_data),   e_rv ? 32'(m_data) : 32'd0);
    check("rsp_id",     32'(bus.rsp_id),     e_rv ? 32'(m_id)   : 32'd0);
    check("rsp_err",    32'(bus.rsp_err),    e_rv ? 32'(m_err)  : 32'd0);
    check("served0",    32'(bus.served0),    32'(sat(m_cnt0, 255)));
    check("served1",    32'(bus.served1),    32'(sat(m_cnt1, 255)));
    check("s_served0",  32'(bus_s.served0),  32'(sat(m_cnt0, 3)));
    check("s_served1",  32'(bus_s.served1),  32'(sat(m_cnt1, 3)));
    acc0 = e_r0;
    acc1 = e_r1;
    if (rst_n) begin
      if (e_r0 || e_r1) begin
        idx    = e_r1 ? int'(bus.req1_idx) : int'(bus.req0_idx);
        m_busy = 1;
        m_age  = 1;
        m_id   = e_r1;
        m_data = tbl(idx);
        m_err  = (idx >= 6);
        m_prio = !m_prio;
        if (e_r0) m_cnt0++; else m_cnt1++;
      end else if (m_busy) begin
        if (m_age >= 2 && bus.rsp_ready) m_busy = 0;
        else m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issues one lookup and returns at the negedge where the response shows.
  task automatic lookup(input bit who, input logic [2:0] idx);
    bit ok;
    ok = 0;
    if (who) begin bus.req1_valid = 1; bus.req1_idx = idx; end
    else     begin bus.req0_valid = 1; bus.req0_idx = idx; end
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      if (who ? bus.req1_ready : bus.req0_ready) begin ok = 1; break; end
      tick();
    end
    tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge sysclk);
        if (bus.rsp_valid) begin ok = 1; break; end
        tick();
      end
    end
    check("lookup_done", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [15:0] b_data [4];
    bit          b_id   [4];
    int          b_cyc  [4];
    int          nr;
    int          e_small [5];
    e_small = '{1, 2, 3, 3, 3};

    rst_n = 0;
    bus.req0_valid = 0; bus.req0_idx = 0;
    bus.req1_valid = 0; bus.req1_idx = 0;
    bus.rsp_ready  = 1;
    tick(); tick(); tick();
    rst_n = 1;

    // Single requester, latency of two cycles.
    bus.req0_valid = 1; bus.req0_idx = 3'd2;
    @(negedge sysclk);
    check("a_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 0;
    @(negedge sysclk);
    check("a_cyc1_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    @(negedge sysclk);
    check("a_valid", 32'(bus.rsp_valid), 32'd1);
    check("a_data",  32'(bus.rsp_data),  32'h0000FEF2);
    check("a_id",    32'(bus.rsp_id),    32'd0);
    check("a_err",   32'(bus.rsp_err),   32'd0);
    check("a_served0", 32'(bus.served0), 32'd1);
    tick();

    // Both requesters contending continuously.
    do_reset();
    bus.req0_valid = 1; bus.req0_idx = 3'd0;
    bus.req1_valid = 1; bus.req1_idx = 3'd5;
    nr = 0;
    for (int i = 0; i < 4; i++) begin b_data[i] = 0; b_id[i] = 0; b_cyc[i] = 0; end
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge sysclk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        b_data[nr] = bus.rsp_data; b_id[nr] = bus.rsp_id; b_cyc[nr] = c; nr++;
      end
      tick();
    end
    check("b_count", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("b_id",   32'(b_id[i]),   32'(i % 2));
      check("b_data", 32'(b_data[i]), (i % 2 == 0) ? 32'h007B : 32'h12AF);
    end
    check("b_first_cyc", 32'(b_cyc[0]), 32'd2);
    for (int i = 1; i < 4; i++) check("b_spacing", 32'(b_cyc[i] - b_cyc[i-1]), 32'd3);
    bus.req0_valid = 0; bus.req1_valid = 0;
    do_reset();

    // Out-of-range index.
    lookup(1, 3'd7);
    check("c_data",    32'(bus.rsp_data), 32'd0);
    check("c_err",     32'(bus.rsp_err),  32'd1);
    check("c_id",      32'(bus.rsp_id),   32'd1);
    check("c_served1", 32'(bus.served1),  32'd1);
    tick();

    // Backpressure in RESP with a competing request waiting.
    bus.rsp_ready = 0;
    lookup(0, 3'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin bus.req1_valid = 1; bus.req1_idx = 3'd4; end
      @(negedge sysclk);
      check("d_hold_valid", 32'(bus.rsp_valid),  32'd1);
      check("d_hold_data",  32'(bus.rsp_data),   32'h04D2);
      check("d_no_ready",   32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    end
    tick();
    bus.rsp_ready = 1;
    @(negedge sysclk);
    check("d_hs_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    @(negedge sysclk);
    check("d_idle_valid",  32'(bus.rsp_valid),  32'd0);
    check("d_idle_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 0;
    repeat (4) tick();

    // Saturating counter on the narrow instance.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      lookup(0, 3'd1);
      check("e_small_served0", 32'(bus_s.served0), 32'(e_small[k]));
      tick();
    end

    // Asynchronous reset while a response is pending.
    bus.rsp_ready = 0;
    lookup(0, 3'd4);
    tick();
    #2;
    rst_n = 0;
    #1;
    check("f_valid_async",   32'(bus.rsp_valid), 32'd0);
    check("f_served0_async", 32'(bus.served0),   32'd0);
    check("f_small_async",   32'(bus_s.served0), 32'd0);
    tick();
    tick();
    rst_n = 1;
    bus.rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sysclk);
      check("f_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end

    // Randomized traffic; requesters hold until accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 9) < 6);
        bus.req0_idx   = 3'($urandom_range(0, 7));
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 9) < 6);
        bus.req1_idx   = 3'($urandom_range(0, 7));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.rsp_ready  = 1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/const_rom_arbiter.md
CONST_ROM_ARBITER -- requirements
Module: const_rom_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0: requester holding priority after reset (0 or 1).
REQ-002 Parameter CNT_W, default 8: width of the per-requester served counters.
REQ-003 sysclk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req0_valid  input  1  requester 0 has a lookup pending.
REQ-006 req0_idx  input  3  requester 0 table index.
REQ-007 req0_ready  output  1  requester 0 lookup accepted this cycle.
REQ-008 req1_valid, req1_idx, req1_ready  same widths/meaning as REQ-005..007 for requester 1.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_data  output  16  constant read from table.
REQ-012 rsp_id  output  1  requester that owns the response.
REQ-013 rsp_err  output  1  index out of range (6 or 7).
REQ-014 served0, served1  output  CNT_W  accepted-lookup counts per requester.

Function
REQ-015 Table (fixed, read-only): idx0=16'h007B, idx1=16'h0B77, idx2=16'hFEF2, idx3=16'h04D2, idx4=16'h064A, idx5=16'h12AF.
REQ-016 Table read modelled as registered: address captured in READ, data valid the following cycle.
REQ-017 FSM states IDLE, READ, RESP; reset state IDLE.
REQ-018 IDLE: if any reqN_valid, grant one, assert its reqN_ready combinationally that cycle, latch idx and id, go READ; else stay IDLE.
REQ-019 reqN_ready shall be 1 only in IDLE, only for the granted requester, and only when its valid is 1; never both readies high.
REQ-020 Arbitration: single requester valid -> it wins; both valid -> priority holder wins.
REQ-021 Priority flips to the other requester after every grant, including uncontested grants.
REQ-022 READ: one cycle, always go RESP.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_id/rsp_err held stable until rsp_valid&&rsp_ready; on that cycle go IDLE.
REQ-024 Latency: acceptance at cycle N -> rsp_valid first high at N+2; back-to-back throughput one lookup per 3 cycles with rsp_ready tied high.
REQ-025 No new acceptance while in READ or RESP; requesters must hold valid/idx until ready.
REQ-026 idx 6 or 7: rsp_data=16'h0000, rsp_err=1; otherwise rsp_err=0.
REQ-027 servedN increments by 1 on each acceptance of requester N; saturates at all-ones (no wrap).
REQ-028 Outputs rsp_data, rsp_id, rsp_err driven 0 whenever rsp_valid=0.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, priority=RR_INIT, served0=served1=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req0_ready=req1_ready=0.
REQ-030 Reset during READ or RESP discards the in-flight lookup; no response after rst_n rises.
REQ-031 First grant eligible on the first rising edge with rst_n high.

Verification
REQ-032 Reset, RR_INIT=0, req0 idx=2 alone, rsp_ready=1 -> req0_ready high cycle 0, rsp_valid cycle 2 with data 16'hFEF2, id 0, err 0; served0=1.
REQ-033 Both valid continuously (req0 idx0, req1 idx5), rsp_ready=1 -> responses alternate id 0 (16'h007B), id 1 (16'h12AF), id 0, ... every 3 cycles.
REQ-034 req1 idx=7 -> rsp_data 16'h0000, rsp_err 1, id 1; served1 increments.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_* stable, no ready to either requester; releases on handshake, returns IDLE next cycle.
REQ-036 CNT_W=2, 5 req0 lookups -> served0 reads 1,2,3,3,3.
REQ-037 rst_n pulsed low during RESP -> rsp_valid drops immediately (asynchronous), counters 0, no response after release.
